// File: rtl/somador_pkg.sv
// Shared widths and helpers for the six-operand nibble adder.
// Operand, pair-sum and total widths are fixed here so all files agree.
package somador_pkg;

   localparam int W      = 4;
   localparam int SUM_W  = 7;
   localparam int PAIR_W = W + 1;

   // Zero-extend a pair sum to total width before the stage-2 add.
   function automatic logic [SUM_W-1:0] widen_pair(input logic [PAIR_W-1:0] p);
      return {{(SUM_W-PAIR_W){1'b0}}, p};
   endfunction

endpackage

// File: rtl/somador_par.sv
// Combinational W+W -> W+1 bit ripple-carry adder built from full adders.
// The carry-out becomes the MSB, so the result never overflows.
module somador_par
   import somador_pkg::*;
(
   input  logic [W-1:0]      i_a,
   input  logic [W-1:0]      i_b,
   output logic [PAIR_W-1:0] o_s
);

   logic [W:0] w_c;

   assign w_c[0] = 1'b0;

   for (genvar gi = 0; gi < W; gi++) begin : g_fa
      logic w_x;
      assign w_x         = i_a[gi] ^ i_b[gi];
      assign o_s[gi]     = w_x ^ w_c[gi];
      assign w_c[gi+1]   = (i_a[gi] & i_b[gi]) | (w_c[gi] & w_x);
   end

   assign o_s[W] = w_c[W];

endmodule

// File: rtl/somador.sv
// Two-stage pipelined sum of six unsigned nibbles with an odd-total flag.
// Stage 1 registers three pair sums; stage 2 registers the total and its LSB.
module somador
   import somador_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [W-1:0]     m0,
   input  logic [W-1:0]     m1,
   input  logic [W-1:0]     m2,
   input  logic [W-1:0]     m3,
   input  logic [W-1:0]     m4,
   input  logic [W-1:0]     m5,
   output logic             out_valid,
   output logic [SUM_W-1:0] soma,
   output logic             impar
);

   logic [W-1:0]      w_a [3];
   logic [W-1:0]      w_b [3];
   logic [PAIR_W-1:0] w_p [3];
   logic [SUM_W-1:0]  w_total;

   logic [PAIR_W-1:0] r_p [3];
   logic              r_v1;
   logic [SUM_W-1:0]  r_soma;
   logic              r_impar;
   logic              r_out_valid;

   assign w_a[0] = m0;
   assign w_b[0] = m1;
   assign w_a[1] = m2;
   assign w_b[1] = m3;
   assign w_a[2] = m4;
   assign w_b[2] = m5;

   for (genvar gi = 0; gi < 3; gi++) begin : g_pair
      somador_par u_par (
         .i_a (w_a[gi]),
         .i_b (w_b[gi]),
         .o_s (w_p[gi])
      );
   end

   assign w_total = widen_pair(r_p[0]) + widen_pair(r_p[1]) + widen_pair(r_p[2]);

   // Datapath loads every cycle; only the valid bits qualify the outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 3; i++) begin
            r_p[i] <= '0;
         end
         r_v1        <= 1'b0;
         r_soma      <= '0;
         r_impar     <= 1'b0;
         r_out_valid <= 1'b0;
      end else begin
         for (int i = 0; i < 3; i++) begin
            r_p[i] <= w_p[i];
         end
         r_v1        <= in_valid;
         r_soma      <= w_total;
         r_impar     <= w_total[0];
         r_out_valid <= r_v1;
      end
   end

   assign soma      = r_soma;
   assign impar     = r_impar;
   assign out_valid = r_out_valid;

endmodule

// File: tb/tb_somador.sv
// Scoreboard bench for somador: each accepted operand set queues its expected
// total, parity and due cycle; the monitor pops and compares on output.
module tb_somador;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       in_valid = 1'b0;
   logic [3:0] m0 = '0, m1 = '0, m2 = '0, m3 = '0, m4 = '0, m5 = '0;
   logic       out_valid;
   logic [6:0] soma;
   logic       impar;

   typedef struct {
      int s;
      int par;
      int due;
   } exp_t;

   exp_t sb[$];
   exp_t head;
   int   cyc = 0;
   int   n_checks = 0;
   int   n_fail = 0;
   logic exp_hit;

   somador dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .m0        (m0),
      .m1        (m1),
      .m2        (m2),
      .m3        (m3),
      .m4        (m4),
      .m5        (m5),
      .out_valid (out_valid),
      .soma      (soma),
      .impar     (impar)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input int obs, input int expv);
      n_checks++;
      if (obs != expv) begin
         n_fail++;
         $display("FAIL %s: got %0d, want %0d (cycle %0d)", tag, obs, expv, cyc);
      end
   endtask

   // Drive one operand set just after an edge; valid sets carry their expectation.
   task automatic send(input logic v, input logic [3:0] a0, input logic [3:0] a1,
                       input logic [3:0] a2, input logic [3:0] a3,
                       input logic [3:0] a4, input logic [3:0] a5,
                       input int exp_s, input int exp_i);
      exp_t e;
      @(posedge clk);
      #1;
      in_valid = v;
      m0 = a0; m1 = a1; m2 = a2; m3 = a3; m4 = a4; m5 = a5;
      if (v) begin
         e.s   = exp_s;
         e.par = exp_i;
         e.due = cyc + 2;
         sb.push_back(e);
      end
   endtask

   task automatic send_rand(input logic v);
      logic [3:0] r [6];
      int         s;
      int         p;
      s = 0;
      p = 0;
      for (int i = 0; i < 6; i++) begin
         r[i] = 4'($urandom_range(0, 15));
         s += int'(r[i]);
         p ^= int'(r[i][0]);
      end
      send(v, r[0], r[1], r[2], r[3], r[4], r[5], s, p);
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         while (sb.size() > 0 && sb[0].due < cyc) begin
            chk("late_result", cyc, sb[0].due);
            void'(sb.pop_front());
         end
         exp_hit = (sb.size() > 0 && sb[0].due == cyc);
         chk("out_valid", int'(out_valid), int'(exp_hit));
         if (exp_hit) begin
            head = sb.pop_front();
            if (out_valid) begin
               chk("soma", int'(soma), head.s);
               chk("impar", int'(impar), head.par);
               $display("cycle %0d: soma=%0d impar=%0d (want %0d/%0d)",
                        cyc, soma, impar, head.s, head.par);
            end
         end
      end
   end

   initial begin
      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_soma", int'(soma), 0);
      chk("rst_impar", int'(impar), 0);
      chk("rst_out_valid", int'(out_valid), 0);
      @(posedge clk);
      #1 rst = 1'b0;

      // Directed sets, back to back
      send(1'b1, 4'd1, 4'd2, 4'd4,  4'd0, 4'd9, 4'd1, 17, 1);
      send(1'b1, 4'd3, 4'd4, 4'd10, 4'd3, 4'd6, 4'd6, 32, 0);
      send(1'b1, 4'd0, 4'd0, 4'd0,  4'd0, 4'd0, 4'd0, 0,  0);
      send(1'b1, 4'hF, 4'hF, 4'hF,  4'hF, 4'hF, 4'hF, 90, 0);
      send(1'b1, 4'd0, 4'd0, 4'd0,  4'd0, 4'd1, 4'd0, 1,  1);

      // Valid pulse pattern 1,0,1
      send(1'b1, 4'd5, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 5, 1);
      send(1'b0, 4'd7, 4'd7, 4'd7, 4'd7, 4'd7, 4'd7, 0, 0);
      send(1'b1, 4'd2, 4'd2, 4'd0, 4'd0, 4'd0, 4'd0, 4, 0);

      // Asynchronous reset between edges while results are in flight
      send(1'b1, 4'd15, 4'd1, 4'd0, 4'd0, 4'd0, 4'd0, 16, 0);
      send(1'b1, 4'd9,  4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 9,  1);
      send(1'b1, 4'd3,  4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 3,  1);
      #2;
      rst = 1'b1;
      sb.delete();
      #1;
      chk("async_rst_soma", int'(soma), 0);
      chk("async_rst_impar", int'(impar), 0);
      chk("async_rst_out_valid", int'(out_valid), 0);
      in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("held_rst_out_valid", int'(out_valid), 0);
      @(posedge clk);
      #1 rst = 1'b0;
      in_valid = 1'b0;
      send(1'b0, 4'd1, 4'd1, 4'd1, 4'd1, 4'd1, 4'd1, 0, 0);
      send(1'b1, 4'd8, 4'd8, 4'd0, 4'd1, 4'd0, 4'd0, 17, 1);

      // Random sweep with random valid gaps
      for (int i = 0; i < 60; i++) begin
         send_rand(($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0);
      end

      // Drain and confirm every expected result emerged
      @(posedge clk);
      #1 in_valid = 1'b0;
      repeat (4) @(posedge clk);
      @(negedge clk);
      #1;
      chk("scoreboard_drained", sb.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
